// File: rtl/key_schedule.sv
// AES-128 iterative key expansion.
// Holds one 128-bit round key and steps it forward by one round per advance
// request. The full expanded schedule is never stored.

// FIPS-197 S-box lookup for a single byte. Purely combinational constant table.
module sbox_byte (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign out_byte = SBOX[in_byte];

endmodule

module key_schedule #(
   parameter int NR = 10  // only AES-128 (10 rounds) is supported
) (
   input  logic         clk,
   input  logic         reset,      // synchronous, active-low
   input  logic         start,
   input  logic [127:0] key,
   input  logic         advance,
   output logic [127:0] round_key,
   output logic [3:0]   round,
   output logic         valid,
   output logic         done
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   localparam logic [3:0] LAST_STEP = 4'(NR - 1);

   state_e         state_q, state_d;
   logic [127:0]   round_key_q, round_key_d;
   logic [3:0]     round_q, round_d;

   logic [31:0]    w0, w1, w2, w3;
   logic [31:0]    rot_word, sub_word, t_word;
   logic [31:0]    nw0, nw1, nw2, nw3;
   logic [127:0]   next_key;
   logic [3:0]     rcon_idx;

   // Round constant for the round being produced (index 1..10).
   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   endfunction

   assign w0 = round_key_q[127:96];
   assign w1 = round_key_q[95:64];
   assign w2 = round_key_q[63:32];
   assign w3 = round_key_q[31:0];

   // RotWord: byte 0 (most significant) moves to the least significant position.
   assign rot_word = {w3[23:0], w3[31:24]};

   sbox_byte u_sbox0 (.in_byte(rot_word[31:24]), .out_byte(sub_word[31:24]));
   sbox_byte u_sbox1 (.in_byte(rot_word[23:16]), .out_byte(sub_word[23:16]));
   sbox_byte u_sbox2 (.in_byte(rot_word[15:8]),  .out_byte(sub_word[15:8]));
   sbox_byte u_sbox3 (.in_byte(rot_word[7:0]),   .out_byte(sub_word[7:0]));

   // round_q stays at or below NR-1 whenever an advance can be honoured, so this
   // 4-bit sum never wraps on a path that is used.
   assign rcon_idx = round_q + 4'd1;
   assign t_word   = sub_word ^ {rcon(rcon_idx), 24'h000000};

   // Each new word chains off the one just computed.
   assign nw0      = w0 ^ t_word;
   assign nw1      = w1 ^ nw0;
   assign nw2      = w2 ^ nw1;
   assign nw3      = w3 ^ nw2;
   assign next_key = {nw0, nw1, nw2, nw3};

   // Next-state and next-key selection; start always overrides advance.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path leaves
      // it unassigned and no latch is inferred.
      state_d     = state_q;
      round_key_d = round_key_q;
      round_d     = round_q;

      if (start) begin
         state_d     = ST_ACTIVE;
         round_key_d = key;
         round_d     = 4'd0;
      end else if (advance && (state_q == ST_ACTIVE)) begin
         round_key_d = next_key;
         round_d     = round_q + 4'd1;
         if (round_q == LAST_STEP) begin
            state_d = ST_DONE;
         end
      end
   end

   // State, round key and round counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
      // independent of statement order.
      if (!reset) begin
         state_q     <= ST_IDLE;
         round_key_q <= '0;
         round_q     <= '0;
      end else begin
         state_q     <= state_d;
         round_key_q <= round_key_d;
         round_q     <= round_d;
      end
   end

   // Status flags decode straight from the state register, so they are as
   // registered as the key itself.
   assign round_key = round_key_q;
   assign round     = round_q;
   assign valid     = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_key_schedule.sv
// Directed bench for key_schedule using FIPS-197 Appendix A key-expansion values.
`timescale 1ns/1ps

module tb_key_schedule;

   logic         clk;
   logic         reset;
   logic         start;
   logic [127:0] key;
   logic         advance;
   logic [127:0] round_key;
   logic [3:0]   round;
   logic         valid;
   logic         done;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   logic [127:0] rk_a [11];

   key_schedule #(.NR(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .key       (key),
      .advance   (advance),
      .round_key (round_key),
      .round     (round),
      .valid     (valid),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock; inputs set after this return are sampled on the next edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic [127:0] exp_key,
                             input logic [3:0] exp_round, input logic exp_valid,
                             input logic exp_done);
      check({tag, ".key"},   round_key, exp_key);
      check({tag, ".round"}, 128'(round), 128'(exp_round));
      check({tag, ".valid"}, 128'(valid), 128'(exp_valid));
      check({tag, ".done"},  128'(done),  128'(exp_done));
   endtask

   task automatic do_start(input logic [127:0] k);
      key   = k;
      start = 1'b1;
      cyc();
      start = 1'b0;
      key   = '0;
   endtask

   initial begin
      rk_a[0]  = KEY_A;
      rk_a[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      rk_a[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      rk_a[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      rk_a[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      rk_a[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      rk_a[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      rk_a[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      rk_a[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      rk_a[9]  = 128'hac7766f319fadc2128d12941575c006e;
      rk_a[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

      reset   = 1'b0;
      start   = 1'b0;
      advance = 1'b0;
      key     = '0;
      cyc();
      cyc();
      check_outs("reset", 128'h0, 4'd0, 1'b0, 1'b0);
      reset = 1'b1;
      cyc();
      check_outs("idle", 128'h0, 4'd0, 1'b0, 1'b0);

      // 1: load and single advance
      do_start(KEY_A);
      check_outs("t1.r0", KEY_A, 4'd0, 1'b1, 1'b0);
      advance = 1'b1;
      cyc();
      advance = 1'b0;
      check_outs("t1.r1", rk_a[1], 4'd1, 1'b1, 1'b0);

      // 2: held advance, full schedule, then pulses in DONE
      do_start(KEY_A);
      advance = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         cyc();
         check_outs($sformatf("t2.r%0d", i), rk_a[i], 4'(i), 1'b1, (i == 10));
      end
      advance = 1'b0;
      for (int i = 0; i < 3; i++) begin
         advance = 1'b1;
         cyc();
         advance = 1'b0;
         cyc();
         check_outs($sformatf("t2.hold%0d", i), rk_a[10], 4'd10, 1'b1, 1'b1);
      end

      // 3: all-zero key
      do_start(128'h0);
      check_outs("t3.r0", 128'h0, 4'd0, 1'b1, 1'b0);
      advance = 1'b1;
      cyc();
      check_outs("t3.r1", 128'h62636363626363636263636362636363, 4'd1, 1'b1, 1'b0);
      for (int i = 2; i <= 10; i++) cyc();
      advance = 1'b0;
      check_outs("t3.r10", 128'hb4ef5bcb3e92e21123e951cf6f8f188e, 4'd10, 1'b1, 1'b1);

      // 4: start and advance together at round 5
      do_start(KEY_A);
      advance = 1'b1;
      for (int i = 1; i <= 5; i++) cyc();
      check_outs("t4.r5", rk_a[5], 4'd5, 1'b1, 1'b0);
      key   = 128'h0;
      start = 1'b1;
      cyc();
      start   = 1'b0;
      advance = 1'b0;
      check_outs("t4.restart", 128'h0, 4'd0, 1'b1, 1'b0);

      // 5: reset mid-schedule, then advance without start
      do_start(KEY_A);
      advance = 1'b1;
      for (int i = 1; i <= 3; i++) cyc();
      advance = 1'b0;
      check_outs("t5.r3", rk_a[3], 4'd3, 1'b1, 1'b0);
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      check_outs("t5.reset", 128'h0, 4'd0, 1'b0, 1'b0);
      advance = 1'b1;
      cyc();
      advance = 1'b0;
      check_outs("t5.idle_adv", 128'h0, 4'd0, 1'b0, 1'b0);

      // 6: advances in IDLE, then gapped advances with junk on key between them
      for (int i = 0; i < 3; i++) begin
         key     = {$urandom, $urandom, $urandom, $urandom};
         advance = 1'b1;
         cyc();
         advance = 1'b0;
         cyc();
      end
      check_outs("t6.idle", 128'h0, 4'd0, 1'b0, 1'b0);
      do_start(KEY_A);
      for (int i = 1; i <= 10; i++) begin
         int gap;
         gap = int'($urandom_range(3, 0));
         for (int g = 0; g < gap; g++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            cyc();
         end
         check($sformatf("t6.gap%0d", i), round_key, rk_a[i-1]);
         key     = {$urandom, $urandom, $urandom, $urandom};
         advance = 1'b1;
         cyc();
         advance = 1'b0;
         check($sformatf("t6.r%0d", i), round_key, rk_a[i]);
      end
      check_outs("t6.final", rk_a[10], 4'd10, 1'b1, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/key_schedule.md
Name: key_schedule

Overview:
Iterative AES-128 key expansion that produces one 128-bit round key per step for the add-round-key stage of the cipher datapath.
- Loads the cipher key on `start`.
- Presents round key 0, then advances to round keys 1..10 on each `advance` request, one round per cycle.
- Holds only the current round key. It never stores the full expanded schedule.
- Output `round_key` connects directly to the add-round-key stage's `w` input.

Parameters:
NR, 10, number of cipher rounds; only 10 (AES-128) is supported; sizes round counter and done condition

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset asserted, sampled on clk rising edge)
start  input  1  single-cycle request: load `key` and restart schedule at round 0
key  input  128  cipher key; byte 0 in [127:120]; sampled only when start=1
advance  input  1  request next round key; honoured only in ACTIVE state
round_key  output  128  current round key, same byte order as key
round  output  4  index of round_key, 0..NR
valid  output  1  round_key/round are valid
done  output  1  round_key is the final round key (round==NR)

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE, round_key=0, round=0, valid=0, done=0. Reset takes priority over start and advance.
- State machine:
  - IDLE --start--> ACTIVE.
  - ACTIVE --advance with round==NR-1--> DONE.
  - ACTIVE --start--> ACTIVE, with the schedule restarted.
  - DONE --start--> ACTIVE.
  - No other transitions.
- start, any state:
  - Next cycle: round_key=key, round=0, valid=1, done=0.
  - Latency is 1 cycle from the start edge to a valid key 0.
- advance in ACTIVE (start=0):
  - Next cycle: round_key=next key, round=round+1.
  - done=1 when the new round==NR.
  - Throughput is 1 round/cycle if advance is held high.
- advance in IDLE or DONE: ignored; outputs hold.
- start and advance asserted in the same cycle: start wins; schedule reloads to round 0.
- Outputs are registered and hold steady between advances. valid stays 1 in ACTIVE and DONE.
- Next-key computation, with w0..w3 = round_key[127:96], [95:64], [63:32], [31:0]:
  - t = SubWord(RotWord(w3)) XOR {Rcon[round+1], 24'h0}.
  - RotWord: bytes [b0 b1 b2 b3] -> [b1 b2 b3 b0].
  - SubWord: FIPS-197 S-box applied to each of the 4 bytes. A combinational byte-lookup sub-module instantiated 4 times is permitted; it must be purely combinational.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 (constant table indexed by round+1).
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - All XORs are bitwise. No carries or width growth.
- The round counter never exceeds NR. Advancing is impossible in DONE, so there is no wrap-around.
- Reset mid-schedule: outputs return to reset values on the next edge. A later start behaves as from IDLE.
- X on key is permitted while start=0. round_key must not depend on key except at a start edge.

Test Plan:
1. Reset → start with key=2b7e151628aed2a6abf7158809cf4f3c, then advance ×1 → cycle after start: round_key=key, round=0, valid=1; after the advance: round_key=a0fafe1788542cb123a339392a6c7605, round=1.
2. Same key, advance held high for 10 cycles → round 2 = f2c295f27a96b9435935807a7359f67f; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with done=1. Further advance pulses leave outputs unchanged.
3. key=0, advance ×10 → round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e, done=1.
4. At round 5, assert start and advance together with key=0 → next cycle: round=0, round_key=0, done=0. The advance is ignored.
5. At round 3, reset=0 for one cycle → next edge: valid=0, round=0, round_key=0, done=0. A subsequent advance without start leaves state IDLE.
6. Advance pulses in IDLE before any start, and gaps of random idle cycles between advances → outputs hold. Final round-10 key still matches case 2.
